// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - state encoding and width helper for the bit-serial subtractor
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Ceiling log2, never below 1 so a WIDTH=1 build still gets a real counter bit.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) bits++;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - combinational 1-bit full subtractor cell
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borr
);

  assign diff = a ^ b ^ bin;
  assign borr = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - LSB-first bit-serial A - B - bin controller around one shared full_sub cell
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] sh_d_next;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;

  full_sub u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (brw),
    .diff (cell_d),
    .borr (cell_bo)
  );

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Insert the fresh difference bit at the MSB; written this way so WIDTH=1 needs no slicing.
  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = cell_d;
  end
  assign sh_d_next = (sh_d >> 1) | d_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_d       <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_d  <= '0;
            brw   <= bin_in;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_d <= sh_d_next;
          brw  <= cell_bo;
          if (last_bit) begin
            cnt        <= '0;
            diff       <= sh_d_next;
            borrow_out <= cell_bo;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1 builds)
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  logic start1, a1, b1, bin1, busy1, done1, diff1, bo1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .bin_in     (bin1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (bo1)
  );

  // Reference: {borrow, difference mod 2^w} from plain integer arithmetic.
  function automatic logic [32:0] ref_sub(input int w, input int av, input int bv, input int bn);
    longint r;
    logic [32:0] res;
    r = longint'(av) - longint'(bv) - longint'(bn);
    res = '0;
    res[31:0] = 32'(r & ((longint'(1) << w) - 1));
    res[32]   = (av < bv + bn);
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=8 operation; optionally pokes start mid-RUN with junk operands.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bn, input bit poke);
    logic [32:0] exp;
    logic [7:0]  held;
    exp  = ref_sub(8, int'(av), int'(bv), int'(bn));
    held = diff;
    start = 1'b1; a = av; b = bv; bin_in = bn;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_diff_hold", diff, held);
      a = 8'($urandom); b = 8'($urandom); bin_in = 1'($urandom);
      start = (poke && i == 3) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("diff", diff, exp[7:0]);
    chk("borrow_out", borrow_out, exp[32]);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_done", done, 0);
      chk("idle_diff_hold", diff, exp[7:0]);
    end
  endtask

  initial begin
    logic [32:0] e1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin_in = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    rst = 1'b0;
    step();

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0);

    // Back-to-back: start held through DONE.
    start = 1'b1; a = 8'hFF; b = 8'hFF; bin_in = 1'b0;
    step();
    a = 8'h80; b = 8'h01;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_busy1", busy, 1);
      step();
    end
    chk("b2b_done1", done, 1);
    chk("b2b_diff1", diff, 8'h00);
    chk("b2b_borrow1", borrow_out, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_busy2", busy, 1);
      chk("b2b_nodone", done, 0);
      step();
    end
    chk("b2b_done2", done, 1);
    chk("b2b_diff2", diff, 8'h7F);
    chk("b2b_borrow2", borrow_out, 0);
    step();
    chk("b2b_idle", done, 0);

    for (int n = 0; n < 20; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    run_op(8'hC3, 8'h5A, 1'b0, 1'b1);
    run_op(8'h12, 8'hE4, 1'b1, 1'b1);

    // Reset during RUN cycle 4.
    start = 1'b1; a = 8'h44; b = 8'h11; bin_in = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", borrow_out, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_nodone", done, 0);
      chk("post_rst_busy", busy, 0);
      step();
    end
    run_op(8'h37, 8'h99, 1'b1, 1'b0);

    // WIDTH=1 sweep of the full-subtractor truth table.
    for (int i = 0; i < 8; i++) begin
      e1 = ref_sub(1, (i >> 2) & 1, (i >> 1) & 1, i & 1);
      start1 = 1'b1; a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); bin1 = 1'(i & 1);
      step();
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; bin1 = ~bin1;
      chk("w1_busy", busy1, 1);
      chk("w1_nodone", done1, 0);
      step();
      chk("w1_done", done1, 1);
      chk("w1_diff", diff1, e1[0]);
      chk("w1_borrow", bo1, e1[32]);
      step();
      chk("w1_idle", done1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It time-shares one 1-bit full-subtractor cell to compute A − B − bin_in over WIDTH cycles, LSB first, with a registered borrow chain. It is used where area matters more than latency and sits between a requesting datapath (start/done handshake) and the shared 1-bit cell.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32)
- CNT_W, $clog2(WIDTH) (min 1), bit-counter width; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled at clk edge, accepted only in IDLE or DONE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin_in  input  1  initial borrow; captured on accepted start
- busy  output  1  high while state = RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result register (A − B − bin_in) mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 means a < b + bin_in (unsigned)

Behaviour:
- Reset (async, immediate): state = IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0, shift regs = 0, counter = 0, borrow reg = 0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, load sh_a ← a, sh_b ← b, brw ← bin_in, cnt ← 0, go to RUN.
- RUN, each cycle:
  - Cell inputs: a_bit = sh_a[0], b_bit = sh_b[0], bin = brw.
  - Cell outputs: d = a^b^bin; bo = (~a&b) | (~(a^b)&bin).
  - Update: sh_a, sh_b shift right 1; sh_d shifts right with d inserted at MSB; brw ← bo; cnt ← cnt+1.
  - When cnt == WIDTH−1, go to DONE this edge.
- Entering DONE: diff ← final sh_d (including the last bit), borrow_out ← final bo. DONE lasts exactly one cycle with done=1.
- DONE: start=1 is accepted exactly as in IDLE (back-to-back, next RUN begins on the following cycle). Otherwise go to IDLE.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+WIDTH; done=1 during the cycle following edge k+WIDTH. Throughput is one op per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled, and no error is flagged.
- a, b, bin_in may change freely after capture without affecting the result.
- diff and borrow_out change only on entry to DONE (or reset), and hold until the next DONE. They do not toggle during RUN.
- Reset asserted mid-RUN aborts the operation: outputs clear and done is not produced.
- WIDTH=1: RUN lasts a single cycle and cnt is stuck at 0. It must still work.
- All arithmetic is unsigned modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package serial_sub_pkg:
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10. 2'b11 is illegal and recovers to IDLE.
  - clog2 helper function for CNT_W.
- One sub-module, full_sub (ports a, b, bin, diff, borr), instantiated once as the shared 1-bit cell. It is purely combinational.
- The controller holds the FSM, counter, shift registers and borrow register.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, bin_in=0, start 1 cycle -> busy high 8 cycles, done pulse in cycle 9, diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01, bin_in=0 -> diff=8'hFF, borrow_out=1. Then a=8'h10, b=8'h0F, bin_in=1 -> diff=8'h00, borrow_out=0.
- Back-to-back: start held high through DONE with a=8'hFF, b=8'hFF then a=8'h80, b=8'h01 -> two done pulses 9 cycles apart, with results 8'h00/0 then 8'h7F/0.
- start pulsed mid-RUN with different operands -> ignored. Result matches the first operands and the done count equals 1.
- rst asserted at RUN cycle 4 -> busy, done, diff and borrow_out are 0 immediately. After release, no spurious done appears, and a new op completes correctly.
- WIDTH=1 build: sweep all 8 {a,b,bin_in} combinations -> done 2 cycles after start. {diff, borrow_out} match the full-subtractor truth table: 00,11,11,01,10,00,00,11.
